// File: rtl/data_sync_ctrl_pkg.sv
// Shared definitions for the data_sync_ctrl receiver.
// This package holds the FSM encoding and the allowed synchronizer depth range.
package data_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    HOLD    = 2'b10
  } state_t;

  localparam int NUM_STAGES_DEF = 2;
  localparam int NUM_STAGES_MIN = 2;
  localparam int NUM_STAGES_MAX = 4;

endpackage

// File: rtl/data_sync_ctrl_en_sync_chain.sv
// Single-bit multi-flop synchronizer that brings BUS_EN into the CLK domain.
// The NUM_STAGES parameter must be in the range 2..4; the output is taken from the last flop.
module en_sync_chain
  import data_sync_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUS_EN,
  output logic en_sync
);

  logic [NUM_STAGES-1:0] en_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) en_s <= '0;
    else      en_s <= {en_s[NUM_STAGES-2:0], BUS_EN};
  end

  assign en_sync = en_s[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_ctrl.sv
// Destination-side receiver: synchronizes BUS_EN, captures UNSYNC_BUS once per enable phase.
// Optional saturating capture counter on CAPT_CNT when DATA_SYNC_CAPT_CNT_EN is defined.
module data_sync_ctrl
  import data_sync_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int BUS_WIDTH  = 8
`ifdef DATA_SYNC_CAPT_CNT_EN
  ,
  parameter int CNT_WIDTH  = 8
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_EN,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE
`ifdef DATA_SYNC_CAPT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] CAPT_CNT
`endif
);

  state_t state, state_nxt;
  logic   en_sync;
  logic   en_prev;
  logic   rise;
  logic   capt;

  en_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_en_sync_chain (
    .CLK     (CLK),
    .RST     (RST),
    .BUS_EN  (BUS_EN),
    .en_sync (en_sync)
  );

  // Edge detect stage
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) en_prev <= 1'b0;
    else      en_prev <= en_sync;
  end

  assign rise = en_sync & ~en_prev;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Capture happens only when leaving IDLE, so one synchronized high phase yields one pulse
  always_comb begin
    state_nxt = state;
    capt      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = CAPTURE;
          capt      = 1'b1;
        end
      end
      CAPTURE: state_nxt = en_sync ? HOLD : IDLE;
      HOLD:    if (!en_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture stage
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SYNC_BUS     <= '0;
      ENABLE_PULSE <= 1'b0;
    end else begin
      SYNC_BUS     <= capt ? UNSYNC_BUS : SYNC_BUS;
      ENABLE_PULSE <= capt;
    end
  end

`ifdef DATA_SYNC_CAPT_CNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      CAPT_CNT <= '0;
    else if (capt) CAPT_CNT <= sat_inc(CAPT_CNT);
  end
`endif

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Scoreboard bench for data_sync_ctrl: two instances (NUM_STAGES 2 and 3) share stimulus.
// Counter checks are compiled when DATA_SYNC_CAPT_CNT_EN is defined.
module tb_data_sync_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] UNSYNC_BUS;
  logic       BUS_EN;
  logic [7:0] sync2, sync3;
  logic       pulse2, pulse3;
`ifdef DATA_SYNC_CAPT_CNT_EN
  logic [1:0] cnt2, cnt3;
`endif

  int n_asserts = 0;
  int n_fail    = 0;
  int edge_cnt  = 0;

  typedef struct {
    logic [7:0] data;
    int         edge_n;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  data_sync_ctrl #(
    .NUM_STAGES(2), .BUS_WIDTH(8)
`ifdef DATA_SYNC_CAPT_CNT_EN
    , .CNT_WIDTH(2)
`endif
  ) dut2 (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_EN(BUS_EN),
    .SYNC_BUS(sync2), .ENABLE_PULSE(pulse2)
`ifdef DATA_SYNC_CAPT_CNT_EN
    , .CAPT_CNT(cnt2)
`endif
  );

  data_sync_ctrl #(
    .NUM_STAGES(3), .BUS_WIDTH(8)
`ifdef DATA_SYNC_CAPT_CNT_EN
    , .CNT_WIDTH(2)
`endif
  ) dut3 (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_EN(BUS_EN),
    .SYNC_BUS(sync3), .ENABLE_PULSE(pulse3)
`ifdef DATA_SYNC_CAPT_CNT_EN
    , .CAPT_CNT(cnt3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // BUS_EN driven just after edge k is first sampled at k+1; pulse follows NUM_STAGES edges later
  task automatic push(input logic [7:0] d);
    q2.push_back('{data: d, edge_n: edge_cnt + 1 + 2});
    q3.push_back('{data: d, edge_n: edge_cnt + 1 + 3});
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (pulse2) begin
      if (q2.size() == 0) check("ns2_spurious_pulse", 32'(pulse2), 0);
      else begin
        e = q2.pop_front();
        check("ns2_pulse_edge", edge_cnt, e.edge_n);
        check("ns2_capture_data", 32'(sync2), 32'(e.data));
      end
    end else if (q2.size() != 0 && edge_cnt > q2[0].edge_n) begin
      check("ns2_pulse_missing", 32'(pulse2), 1);
      e = q2.pop_front();
    end
    if (pulse3) begin
      if (q3.size() == 0) check("ns3_spurious_pulse", 32'(pulse3), 0);
      else begin
        e = q3.pop_front();
        check("ns3_pulse_edge", edge_cnt, e.edge_n);
        check("ns3_capture_data", 32'(sync3), 32'(e.data));
      end
    end else if (q3.size() != 0 && edge_cnt > q3[0].edge_n) begin
      check("ns3_pulse_missing", 32'(pulse3), 1);
      e = q3.pop_front();
    end
  end

  task automatic check_hold(input string tag, input logic [7:0] d);
    check({tag, "_ns2"}, 32'(sync2), 32'(d));
    check({tag, "_ns3"}, 32'(sync3), 32'(d));
  endtask

  task automatic transfer(input logic [7:0] d, input int hi, input int lo);
    @(posedge CLK); #1 UNSYNC_BUS = d;
    @(posedge CLK); #1 BUS_EN = 1'b1;
    push(d);
    repeat (hi) @(posedge CLK);
    #1 BUS_EN = 1'b0;
    repeat (lo) @(posedge CLK);
    #1 check_hold("xfer_hold", d);
  endtask

  initial begin
    // Reset with BUS_EN already high
    RST = 1'b0; BUS_EN = 1'b1; UNSYNC_BUS = 8'hA5;
    repeat (3) @(posedge CLK);
    #1;
    check_hold("reset_sync_bus", 8'h00);
    check("reset_pulse_ns2", 32'(pulse2), 0);
    check("reset_pulse_ns3", 32'(pulse3), 0);
    @(posedge CLK); #1 RST = 1'b1;
    push(8'hA5);
    repeat (8) @(posedge CLK);
    #1 check_hold("post_reset_capture", 8'hA5);
    BUS_EN = 1'b0;
    repeat (6) @(posedge CLK);

    // Latency with a single clean transfer
    transfer(8'h3C, 6, 6);

    // Long enable, bus changes mid-HOLD
    @(posedge CLK); #1 UNSYNC_BUS = 8'h77;
    @(posedge CLK); #1 BUS_EN = 1'b1;
    push(8'h77);
    repeat (20) @(posedge CLK);
    #1 UNSYNC_BUS = 8'hFF;
    repeat (30) @(posedge CLK);
    #1 check_hold("long_enable_hold", 8'h77);
    BUS_EN = 1'b0;
    repeat (6) @(posedge CLK);

    // Back-to-back transfers
    transfer(8'h11, 4, 4);
    transfer(8'h22, 4, 4);

    // Reset asserted mid-HOLD, released with BUS_EN still high
    @(posedge CLK); #1 UNSYNC_BUS = 8'h5A;
    @(posedge CLK); #1 BUS_EN = 1'b1;
    push(8'h5A);
    repeat (10) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check_hold("mid_hold_reset_clear", 8'h00);
    check("mid_hold_reset_pulse_ns2", 32'(pulse2), 0);
    check("mid_hold_reset_pulse_ns3", 32'(pulse3), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    push(8'h5A);
    repeat (10) @(posedge CLK);
    #1 check_hold("mid_hold_recapture", 8'h5A);
    BUS_EN = 1'b0;
    repeat (6) @(posedge CLK);

`ifdef DATA_SYNC_CAPT_CNT_EN
    // Saturating counter from a fresh reset
    @(posedge CLK); #1 RST = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    check("cnt_reset_ns2", 32'(cnt2), 0);
    check("cnt_reset_ns3", 32'(cnt3), 0);
    for (int i = 0; i < 5; i++) begin
      transfer(8'(8'h40 + i), 4, 4);
      check("capt_cnt_ns2", 32'(cnt2), (i < 3) ? i + 1 : 3);
      check("capt_cnt_ns3", 32'(cnt3), (i < 3) ? i + 1 : 3);
    end
`endif

    repeat (8) @(posedge CLK);
    #1;
    check("ns2_queue_drained", q2.size(), 0);
    check("ns3_queue_drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
